// File: rtl/xm_access_port_pkg.sv
// xv: shared types for the VRAM access port.
//   host_reg_e  - host register select encoding carried on host_reg_i
//   xm_state_e  - access sequencer states
//   ch_width()  - channel-selector width, never narrower than one bit
package xv;

    typedef enum logic [2:0] {
        REG_RD_INCR = 3'd0,
        REG_RD_ADDR = 3'd1,
        REG_WR_INCR = 3'd2,
        REG_WR_ADDR = 3'd3,
        REG_DATA    = 3'd4
    } host_reg_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } xm_state_e;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xm_access_port_if.sv
// VRAM request/acknowledge bus.
//   master (access port): mem_sel_o, mem_wr_o, mem_addr_o, mem_data_o out;
//                         mem_ack_i, mem_data_i in
//   slave  (VRAM side)  : the reverse
// A request is held stable from mem_sel_o rising until mem_ack_i is seen.
interface xm_access_port_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_sel_o;
    logic              mem_wr_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;

    modport master (
        output mem_sel_o, mem_wr_o, mem_addr_o, mem_data_o,
        input  mem_ack_i, mem_data_i
    );

    modport slave (
        input  mem_sel_o, mem_wr_o, mem_addr_o, mem_data_o,
        output mem_ack_i, mem_data_i
    );
endinterface

// File: rtl/xm_access_port_wfifo.sv
// xm_wfifo: posted-write FIFO holding {addr,data} entries.
//   clk, reset_n_i : clock, async active-low reset (empties the FIFO)
//   push, din      : enqueue (ignored when full)
//   pop            : dequeue head (ignored when empty)
//   dout           : head entry, valid while !empty
//   full, empty    : occupancy flags
module xm_wfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset_n_i,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] ram_q;
    logic [PW-1:0]           wp_q, rp_q;
    logic [PW:0]             cnt_q;
    logic                    do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = ram_q[rp_q];

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ram_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                ram_q[wp_q] <= din;
                wp_q        <= wp_q + 1'b1;
            end
            if (do_pop)
                rp_q <= rp_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/xm_access_port.sv
// xm_access_port: host register port onto VRAM with NUM_CH auto-increment
// channels. Writes are posted through a FIFO; each channel keeps one word
// prefetched at its read address.
//   clk, reset_n_i            : pixel clock, async active-low reset
//   host_wr_i / host_rd_i     : register-write / DATA-read strobes
//   host_ch_i, host_reg_i     : channel and register select
//   host_data_i / host_data_o : write word / prefetched word of host_ch_i
//   rd_valid_o                : per-channel prefetched-word-valid
//   wfifo_full_o, ovf_o       : FIFO full, dropped DATA write pulse
//   busy_o                    : access in flight, FIFO non-empty or read pending
//   mem                       : VRAM request bus (master side)
module xm_access_port
    import xv::*;
#(
    parameter int  NUM_CH      = 2,
    parameter int  WFIFO_DEPTH = 4,
    parameter int  ADDR_W      = 16,
    parameter int  DATA_W      = 16,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              host_wr_i,
    input  logic              host_rd_i,
    input  logic [CH_W-1:0]   host_ch_i,
    input  logic [2:0]        host_reg_i,
    input  logic [DATA_W-1:0] host_data_i,
    output logic [DATA_W-1:0] host_data_o,
    output logic [NUM_CH-1:0] rd_valid_o,
    output logic              wfifo_full_o,
    output logic              ovf_o,
    output logic              busy_o,
    xm_access_port_if.master  mem
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    // per-channel state
    logic [NUM_CH-1:0][ADDR_W-1:0] rd_addr_q, rd_incr_q, wr_addr_q, wr_incr_q;
    logic [NUM_CH-1:0][DATA_W-1:0] rd_data_q;
    logic [NUM_CH-1:0]             rd_valid_q, pend_q;

    // host decode
    host_reg_e         reg_sel;
    logic [ADDR_W-1:0] host_addr, sel_wr_addr;
    logic [NUM_CH-1:0] ch_hit, reg_wr, rd_addr_wr, rd_take, rd_done;
    logic              data_wr;

    // FIFO
    wr_ent_t push_ent, head_ent;
    logic    fifo_push, fifo_pop, fifo_full, fifo_empty;

    // sequencer
    xm_state_e         state_q, state_d;
    logic              load_wr, load_rd, ack;
    logic [CH_W-1:0]   pick_ch, srv_ch_q, rr_q;
    int                best_d;
    logic              stale_q, ovf_q, mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;

    assign reg_sel   = host_reg_e'(host_reg_i);
    assign host_addr = ADDR_W'(host_data_i);

    always_comb begin
        ch_hit      = '0;
        sel_wr_addr = '0;
        host_data_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (host_ch_i == CH_W'(c)) begin
                ch_hit[c]   = 1'b1;
                sel_wr_addr = wr_addr_q[c];
                host_data_o = rd_data_q[c];
            end
        end
    end

    // ack only counts while a request is actually on the bus
    assign ack = mem.mem_ack_i && (state_q != ST_IDLE);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign reg_wr[c]     = host_wr_i && ch_hit[c];
        assign rd_addr_wr[c] = reg_wr[c] && (reg_sel == REG_RD_ADDR);
        assign rd_take[c]    = host_rd_i && ch_hit[c] && rd_valid_q[c];
        // stale data (address rewritten in flight) is never delivered
        assign rd_done[c]    = ack && (state_q == ST_READ) &&
                               (srv_ch_q == CH_W'(c)) && !stale_q;
    end

    assign data_wr   = host_wr_i && (reg_sel == REG_DATA) && (|ch_hit);
    // full is judged on this cycle's occupancy, a same-cycle pop does not help
    assign fifo_push = data_wr && !fifo_full;
    assign fifo_pop  = ack && (state_q == ST_WRITE);
    assign push_ent  = '{addr: sel_wr_addr, data: host_data_i};

    xm_wfifo #(
        .DEPTH (WFIFO_DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_wfifo (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .din       (push_ent),
        .dout      (head_ent),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_addr_q  <= '0;
            rd_incr_q  <= '0;
            wr_addr_q  <= '0;
            wr_incr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            pend_q     <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (reg_wr[c]) begin
                    case (reg_sel)
                        REG_RD_INCR: rd_incr_q[c] <= host_addr;
                        REG_WR_INCR: wr_incr_q[c] <= host_addr;
                        REG_WR_ADDR: wr_addr_q[c] <= host_addr;
                        default: ;
                    endcase
                end
                if (fifo_push && ch_hit[c])
                    wr_addr_q[c] <= wr_addr_q[c] + wr_incr_q[c];

                // address reload beats a consume, which beats a fill
                if (rd_addr_wr[c]) begin
                    rd_addr_q[c]  <= host_addr;
                    rd_valid_q[c] <= 1'b0;
                    pend_q[c]     <= 1'b1;
                end else if (rd_take[c]) begin
                    rd_addr_q[c]  <= rd_addr_q[c] + rd_incr_q[c];
                    rd_valid_q[c] <= 1'b0;
                    pend_q[c]     <= 1'b1;
                end else if (rd_done[c]) begin
                    rd_data_q[c]  <= mem.mem_data_i;
                    rd_valid_q[c] <= 1'b1;
                    pend_q[c]     <= 1'b0;
                end
            end
        end
    end

    // round-robin: nearest pending channel at or after rr_q
    always_comb begin
        pick_ch = '0;
        best_d  = NUM_CH;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pend_q[c] && (((c + NUM_CH - int'(rr_q)) % NUM_CH) < best_d)) begin
                best_d  = (c + NUM_CH - int'(rr_q)) % NUM_CH;
                pick_ch = CH_W'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load_wr = 1'b0;
        load_rd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_WRITE;
                    load_wr = 1'b1;
                end else if (|pend_q) begin
                    state_d = ST_READ;
                    load_rd = 1'b1;
                end
            end
            ST_WRITE, ST_READ: if (mem.mem_ack_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            srv_ch_q   <= '0;
            rr_q       <= '0;
            stale_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= data_wr && fifo_full;
            if (load_wr) begin
                mem_wr_q   <= 1'b1;
                mem_addr_q <= head_ent.addr;
                mem_data_q <= head_ent.data;
            end else if (load_rd) begin
                mem_wr_q   <= 1'b0;
                mem_addr_q <= rd_addr_q[pick_ch];
                srv_ch_q   <= pick_ch;
                rr_q       <= (pick_ch == CH_W'(NUM_CH - 1)) ? '0 : pick_ch + 1'b1;
                // a reload in the issue cycle already makes this read stale
                stale_q    <= rd_addr_wr[pick_ch];
            end else if (state_q == ST_READ) begin
                stale_q    <= stale_q | rd_addr_wr[srv_ch_q];
            end
        end
    end

    assign mem.mem_sel_o  = (state_q != ST_IDLE);
    assign mem.mem_wr_o   = mem_wr_q;
    assign mem.mem_addr_o = mem_addr_q;
    assign mem.mem_data_o = mem_data_q;

    assign rd_valid_o   = rd_valid_q;
    assign wfifo_full_o = fifo_full;
    assign ovf_o        = ovf_q;
    assign busy_o       = mem.mem_sel_o || !fifo_empty || (|pend_q);
endmodule

// File: tb/tb_xm_access_port.sv
// Directed bench for xm_access_port (NUM_CH=2, WFIFO_DEPTH=4, 16/16 bits).
// The VRAM model acks one cycle after mem_sel_o rises and returns
// read data = address + 0x1111; every acked access is logged.
module tb_xm_access_port;
    import xv::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        host_wr = 1'b0, host_rd = 1'b0;
    logic [0:0]  host_ch = '0;
    logic [2:0]  host_reg = '0;
    logic [15:0] host_wdata = '0;
    logic [15:0] host_rdata;
    logic [1:0]  rd_valid;
    logic        wfifo_full, ovf, busy;

    logic        ack_en = 1'b0, one_shot = 1'b0, stray = 1'b0;
    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];
    logic        log_wr[$];
    int          ovf_cnt = 0;
    int          n_chk = 0, n_err = 0;

    xm_access_port_if #(.ADDR_W(16), .DATA_W(16)) m();

    xm_access_port #(
        .NUM_CH(2), .WFIFO_DEPTH(4), .ADDR_W(16), .DATA_W(16)
    ) dut (
        .clk          (clk),
        .reset_n_i    (reset_n),
        .host_wr_i    (host_wr),
        .host_rd_i    (host_rd),
        .host_ch_i    (host_ch),
        .host_reg_i   (host_reg),
        .host_data_i  (host_wdata),
        .host_data_o  (host_rdata),
        .rd_valid_o   (rd_valid),
        .wfifo_full_o (wfifo_full),
        .ovf_o        (ovf),
        .busy_o       (busy),
        .mem          (m)
    );

    always #5 clk = ~clk;

    // VRAM model
    always @(negedge clk) begin
        if ((ack_en || one_shot) && m.mem_sel_o && !m.mem_ack_i) begin
            m.mem_ack_i  = 1'b1;
            m.mem_data_i = m.mem_addr_o + 16'h1111;
            log_addr.push_back(m.mem_addr_o);
            log_wr.push_back(m.mem_wr_o);
            log_data.push_back(m.mem_wr_o ? m.mem_data_o : m.mem_addr_o + 16'h1111);
            one_shot = 1'b0;
        end else if (stray) begin
            m.mem_ack_i  = 1'b1;
            m.mem_data_i = 16'hDEAD;
            stray = 1'b0;
        end else begin
            m.mem_ack_i = 1'b0;
        end
    end

    always @(negedge clk) if (ovf) ovf_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic acc(input string tag, input int i, input logic wr,
                       input logic [15:0] addr, input logic [15:0] data);
        chk({tag, "_wr"},   32'(log_wr[i]),   32'(wr));
        chk({tag, "_addr"}, 32'(log_addr[i]), 32'(addr));
        chk({tag, "_data"}, 32'(log_data[i]), 32'(data));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hw(input logic ch, input logic [2:0] r, input logic [15:0] d);
        host_ch = ch; host_reg = r; host_wdata = d; host_wr = 1'b1;
        tick(1);
        host_wr = 1'b0;
    endtask

    task automatic hrd(input logic ch);
        host_ch = ch; host_rd = 1'b1;
        tick(1);
        host_rd = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (!busy) break;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic clr_log();
        log_addr.delete(); log_data.delete(); log_wr.delete();
    endtask

    initial begin
        tick(3);
        reset_n = 1'b1;
        chk("rst_sel",   32'(m.mem_sel_o),  0);
        chk("rst_addr",  32'(m.mem_addr_o), 0);
        chk("rst_valid", 32'(rd_valid),     0);
        chk("rst_busy",  32'(busy),         0);
        chk("rst_full",  32'(wfifo_full),   0);

        // posted writes with increment 2
        ack_en = 1'b1;
        hw(0, REG_WR_ADDR, 16'h1000);
        hw(0, REG_WR_INCR, 16'h0002);
        hw(0, REG_DATA,    16'hAAAA);
        hw(0, REG_DATA,    16'hBBBB);
        wait_idle("t1");
        chk("t1_n", log_addr.size(), 2);
        acc("t1_w0", 0, 1'b1, 16'h1000, 16'hAAAA);
        acc("t1_w1", 1, 1'b1, 16'h1002, 16'hBBBB);
        // idle latency: strobe in cycle 0 -> mem_sel_o in cycle 2
        hw(0, REG_DATA, 16'hCCCC);
        chk("t1_lat_c1", 32'(m.mem_sel_o), 0);
        tick(1);
        chk("t1_lat_c2",  32'(m.mem_sel_o),  1);
        chk("t1_wr_addr", 32'(m.mem_addr_o), 32'h1004);
        wait_idle("t1b");

        // address wrap
        clr_log();
        hw(1, REG_WR_ADDR, 16'hFFFF);
        hw(1, REG_WR_INCR, 16'h0001);
        hw(1, REG_DATA,    16'h1234);
        wait_idle("t2a");
        hw(1, REG_DATA,    16'h5678);
        wait_idle("t2b");
        chk("t2_n", log_addr.size(), 2);
        acc("t2_w0", 0, 1'b1, 16'hFFFF, 16'h1234);
        acc("t2_w1", 1, 1'b1, 16'h0000, 16'h5678);

        // overflow: DEPTH+1 writes with the VRAM stalled
        clr_log();
        ack_en = 1'b0;
        hw(0, REG_WR_ADDR, 16'h2000);
        hw(0, REG_WR_INCR, 16'h0001);
        for (int i = 0; i < 5; i++) hw(0, REG_DATA, 16'hD000 + 16'(i));
        tick(3);
        chk("t3_full", 32'(wfifo_full), 1);
        chk("t3_ovf",  32'(ovf_cnt),    1);
        ack_en = 1'b1;
        wait_idle("t3a");
        chk("t3_drain_full", 32'(wfifo_full), 0);
        hw(0, REG_DATA, 16'hE000);
        wait_idle("t3b");
        chk("t3_n", log_addr.size(), 5);
        acc("t3_w0", 0, 1'b1, 16'h2000, 16'hD000);
        acc("t3_w3", 3, 1'b1, 16'h2003, 16'hD003);
        acc("t3_w4", 4, 1'b1, 16'h2004, 16'hE000);

        // write first, then reads ch0, ch1
        clr_log();
        ack_en = 1'b0;
        hw(0, REG_WR_ADDR, 16'h3000);
        hw(0, REG_DATA,    16'h7777);
        hw(0, REG_RD_INCR, 16'h0001);
        hw(0, REG_RD_ADDR, 16'h0400);
        hw(1, REG_RD_ADDR, 16'h0500);
        tick(2);
        ack_en = 1'b1;
        wait_idle("t4a");
        chk("t4_n", log_addr.size(), 3);
        acc("t4_a0", 0, 1'b1, 16'h3000, 16'h7777);
        acc("t4_a1", 1, 1'b0, 16'h0400, 16'h1511);
        acc("t4_a2", 2, 1'b0, 16'h0500, 16'h1611);
        chk("t4_valid", 32'(rd_valid), 32'h3);
        host_ch = 1'b0; #1;
        chk("t4_rd_ch0", 32'(host_rdata), 32'h1511);
        host_ch = 1'b1; #1;
        chk("t4_rd_ch1", 32'(host_rdata), 32'h1611);
        tick(1);
        hrd(0);
        wait_idle("t4b");
        acc("t4_a3", 3, 1'b0, 16'h0401, 16'h1512);
        chk("t4_valid2", 32'(rd_valid), 32'h3);
        host_ch = 1'b0; #1;
        chk("t4_rd_ch0b", 32'(host_rdata), 32'h1512);
        tick(1);

        // RD_ADDR rewritten while the read is in flight
        clr_log();
        ack_en = 1'b0;
        hw(0, REG_RD_ADDR, 16'h0100);
        tick(1);
        chk("t5_sel",  32'(m.mem_sel_o),  1);
        chk("t5_addr", 32'(m.mem_addr_o), 32'h0100);
        hw(0, REG_RD_ADDR, 16'h0200);
        one_shot = 1'b1;
        tick(1);
        chk("t5_discard_valid", 32'(rd_valid), 32'h2);
        chk("t5_discard_busy",  32'(busy),     1);
        ack_en = 1'b1;
        wait_idle("t5");
        chk("t5_n", log_addr.size(), 2);
        acc("t5_a0", 0, 1'b0, 16'h0100, 16'h1211);
        acc("t5_a1", 1, 1'b0, 16'h0200, 16'h1311);
        chk("t5_valid", 32'(rd_valid), 32'h3);
        host_ch = 1'b0; #1;
        chk("t5_rd_ch0", 32'(host_rdata), 32'h1311);
        tick(1);

        // reset during an access, then a stray ack
        clr_log();
        ack_en = 1'b0;
        hw(0, REG_WR_ADDR, 16'h4000);
        hw(0, REG_DATA,    16'h9999);
        tick(2);
        chk("t6_sel_pre", 32'(m.mem_sel_o), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_sel_rst",   32'(m.mem_sel_o),  0);
        chk("t6_addr_rst",  32'(m.mem_addr_o), 0);
        chk("t6_busy_rst",  32'(busy),         0);
        chk("t6_valid_rst", 32'(rd_valid),     0);
        tick(1);
        reset_n = 1'b1;
        stray = 1'b1;
        tick(3);
        chk("t6_stray_sel",   32'(m.mem_sel_o), 0);
        chk("t6_stray_busy",  32'(busy),        0);
        chk("t6_stray_valid", 32'(rd_valid),    0);
        chk("t6_stray_log",   log_addr.size(),  0);
        // cleared wr_addr and round-robin restart at ch0
        hw(1, REG_DATA,    16'h1357);
        hw(1, REG_RD_ADDR, 16'h0600);
        hw(0, REG_RD_ADDR, 16'h0700);
        tick(2);
        ack_en = 1'b1;
        wait_idle("t6");
        chk("t6_n", log_addr.size(), 3);
        acc("t6_a0", 0, 1'b1, 16'h0000, 16'h1357);
        acc("t6_a1", 1, 1'b0, 16'h0700, 16'h1811);
        acc("t6_a2", 2, 1'b0, 16'h0600, 16'h1711);
        chk("t6_ovf_total", 32'(ovf_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/xm_access_port.md
XM_ACCESS_PORT -- requirements
Module: xm_access_port

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent auto-increment channels (1..4); CH_W = max(1,$clog2(NUM_CH)).
REQ-002 SHALL have parameter WFIFO_DEPTH, default 4, posted-write FIFO entries (power of 2, 2..8).
REQ-003 SHALL have parameter ADDR_W, default 16, VRAM address width.
REQ-004 SHALL have parameter DATA_W, default 16, VRAM word width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk in 1, the pixel clock; all state on rising edge.
REQ-006 SHALL have reset_n_i in 1, asynchronous active-low reset.
REQ-007 SHALL have host_wr_i in 1, one-cycle register-write strobe.
REQ-008 SHALL have host_rd_i in 1, one-cycle DATA-read strobe; consumes the prefetched word.
REQ-009 SHALL have host_ch_i in CH_W, channel selector for host strobes and host_data_o.
REQ-010 SHALL have host_reg_i in 3, register select: RD_INCR, RD_ADDR, WR_INCR, WR_ADDR or DATA.
REQ-011 SHALL have host_data_i in DATA_W, register write word.
REQ-012 SHALL have host_data_o out DATA_W, prefetched word of channel host_ch_i (combinational mux).
REQ-013 SHALL have rd_valid_o out NUM_CH, per-channel prefetched-word-valid flags.
REQ-014 SHALL have wfifo_full_o out 1, posted-write FIFO full.
REQ-015 SHALL have ovf_o out 1, one-cycle pulse when a DATA write is dropped.
REQ-016 SHALL have busy_o out 1, high while mem_sel_o, FIFO non-empty, or any read pending.
REQ-017 SHALL have mem_sel_o/mem_wr_o out 1 each, and mem_addr_o out ADDR_W, VRAM request, write flag and address.
REQ-018 SHALL have mem_data_o out DATA_W, VRAM write data.
REQ-019 SHALL have mem_ack_i in 1 and mem_data_i in DATA_W, VRAM ack and read data.

Function
REQ-020 SHALL write RD_INCR/WR_INCR/WR_ADDR of channel host_ch_i on host_wr_i; no memory access.
REQ-021 SHALL, on RD_ADDR write, load rd_addr, clear rd_valid, set read-pending for that channel.
REQ-022 SHALL, on DATA write with FIFO not full, push {wr_addr, host_data_i} and advance wr_addr by wr_incr modulo 2^ADDR_W in the same edge.
REQ-023 SHALL, on DATA write with FIFO full at that cycle (even if popping), drop the write, leave wr_addr unchanged and pulse ovf_o.
REQ-024 SHALL, on host_rd_i with rd_valid set, clear rd_valid, advance rd_addr by rd_incr modulo 2^ADDR_W and set read-pending; with rd_valid clear, ignore host_rd_i.
REQ-025 SHALL run FSM IDLE -> WRITE or READ -> IDLE; in IDLE, FIFO non-empty selects WRITE (head entry), else any read-pending selects READ.
REQ-026 SHALL choose reads round-robin, starting from the channel after the last channel served; the first read after reset starts at channel 0.
REQ-027 SHALL, in WRITE/READ, hold mem_sel_o, mem_wr_o, mem_addr_o and mem_data_o stable until mem_ack_i; then drop mem_sel_o and return to IDLE.
REQ-028 SHALL give idle-port latency as: a strobe in cycle 0 produces mem_sel_o high in cycle 2; mem_sel_o is low at least one cycle between accesses.
REQ-029 SHALL, on WRITE ack, pop the FIFO; on READ ack, store mem_data_i, set rd_valid and clear pending for the served channel.
REQ-030 SHALL, if RD_ADDR of the in-flight channel is rewritten, discard the ack data, leave rd_valid clear and keep pending set, so the read reissues at the new address.
REQ-031 SHALL ignore mem_ack_i while mem_sel_o is low.

Reset
REQ-032 SHALL, on reset_n_i low (asynchronous), force IDLE and clear mem_sel_o, mem_wr_o, mem_addr_o, mem_data_o, ovf_o, all addr/incr registers, rd_valid, pending flags, FIFO and round-robin pointer.
REQ-033 SHALL, after reset release, ignore a mem_ack_i belonging to an aborted access.

Structure
REQ-034 SHALL place the host_reg_i encoding enum and the FSM state enum in package xv.
REQ-035 SHALL implement the posted-write FIFO as sub-module xm_wfifo (synchronous, {addr,data} entries, full/empty flags).

Verification
REQ-036 SHALL test: ch0 WR_ADDR=0x1000, WR_INCR=0x0002, DATA 0xAAAA, 0xBBBB -> writes to 0x1000 then 0x1002; wr_addr ends at 0x1004.
REQ-037 SHALL test: WR_ADDR=0xFFFF, WR_INCR=0x0001, one DATA write -> write to 0xFFFF; wr_addr wraps to 0x0000.
REQ-038 SHALL test: mem_ack_i held low, WFIFO_DEPTH+1 DATA writes -> wfifo_full_o high, last write dropped, ovf_o pulses once, wr_addr advanced by DEPTH only.
REQ-039 SHALL test: ch0 and ch1 RD_ADDR written in one burst while a write is queued -> write served first, then ch0 read, then ch1 read; rd_valid_o=2'b11.
REQ-040 SHALL test: ch0 RD_ADDR=0x0100, then rewritten to 0x0200 before ack -> ack data discarded, reissued read to 0x0200, rd_valid set only after the second ack.
REQ-041 SHALL test: reset_n_i low while mem_sel_o high -> mem_sel_o low immediately; a following stray mem_ack_i changes no state.
